// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus arbiter: state encoding, default timing
// parameters and ST7920 command bytes.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_PULSE     = 3'd2,
        ST_HOLD      = 3'd3,
        ST_WAIT_LONG = 3'd4
    } lcd_state_e;

    localparam int unsigned LCD_CLK_DIV_DEF    = 2500;
    localparam int unsigned LCD_CLEAR_WAIT_DEF = 32;

    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME    = 8'h02;
    localparam logic [7:0] LCD_CMD_BASIC   = 8'h30;
    localparam logic [7:0] LCD_CMD_EXT_GFX = 8'h36;

    // Clear and home need extra settling time inside the controller.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] dat);
        return !rs && ((dat == LCD_CMD_CLEAR) || (dat == LCD_CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Phase timer: wrapping counter with synchronous clear; done_c_o flags the
// last clk of each CLK_DIV-long phase.
module lcd_phase_timer #(
    parameter int unsigned CLK_DIV = 2500
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic done_c_o
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count and wrap at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign done_c_o = en_i && !clr_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Two-requester round-robin arbiter with bus lock and rs/en/data write
// sequencer for an ST7920-class parallel LCD.
// Optional macro LCD_ARB_LONG_CMD_EN: clear/home commands wait a further
// CLEAR_WAIT phases before ack.
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_DIV = LCD_CLK_DIV_DEF
`ifdef LCD_ARB_LONG_CMD_EN
    ,
    parameter int unsigned CLEAR_WAIT = LCD_CLEAR_WAIT_DEF
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       lock0_i,
    input  logic       lock1_i,
    input  logic       rs0_i,
    input  logic       rs1_i,
    input  logic [7:0] dat0_i,
    input  logic [7:0] dat1_i,
    output logic       gnt0_o,
    output logic       gnt1_o,
    output logic       ack0_o,
    output logic       ack1_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_en_o,
    output logic [7:0] lcd_data_o,
    output logic       busy_o
);

    lcd_state_e state_q, state_d;
    logic [1:0] gnt_q, gnt_d, ack_q, ack_d;
    logic       lcd_en_q, lcd_en_d, lcd_rs_q, lcd_rs_d, busy_q, busy_d;
    logic [7:0] lcd_data_q, lcd_data_d;
    logic       own_vld_q, own_vld_d, own_q, own_d;
    logic       last_q, last_d, srv_q, srv_d;
    logic       tmr_clr_c, tmr_done_c;
    logic       win_vld_c, win_id_c, sel_rs_c;
    logic [7:0] sel_dat_c;
    logic [1:0] req_c, lock_c;

`ifdef LCD_ARB_LONG_CMD_EN
    localparam int unsigned WAIT_W = (CLEAR_WAIT > 1) ? $clog2(CLEAR_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CLEAR_WAIT - 1);
    logic              long_q, long_d;
    logic [WAIT_W-1:0] wcnt_q, wcnt_d;
`endif

    assign req_c  = {req1_i, req0_i};
    assign lock_c = {lock1_i, lock0_i};

    lcd_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (tmr_clr_c),
        .en_i     (state_q != ST_IDLE),
        .done_c_o (tmr_done_c)
    );

    // Winner selection: a live lock owner excludes the other side, else round robin.
    always_comb begin
        win_vld_c = 1'b0;
        win_id_c  = 1'b0;
        if (own_vld_q && lock_c[own_q]) begin
            win_vld_c = req_c[own_q];
            win_id_c  = own_q;
        end else if (&req_c) begin
            win_vld_c = 1'b1;
            win_id_c  = ~last_q;
        end else if (req_c[0]) begin
            win_vld_c = 1'b1;
        end else if (req_c[1]) begin
            win_vld_c = 1'b1;
            win_id_c  = 1'b1;
        end
        sel_rs_c  = win_id_c ? rs1_i : rs0_i;
        sel_dat_c = win_id_c ? dat1_i : dat0_i;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next state; the ack cycle is spent in IDLE without arbitrating.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (!(|ack_q) && win_vld_c) state_d = ST_SETUP;
            ST_SETUP: if (tmr_done_c) state_d = ST_PULSE;
            ST_PULSE: if (tmr_done_c) state_d = ST_HOLD;
            ST_HOLD: begin
                if (tmr_done_c) begin
`ifdef LCD_ARB_LONG_CMD_EN
                    state_d = long_q ? ST_WAIT_LONG : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_WAIT_LONG: begin
`ifdef LCD_ARB_LONG_CMD_EN
                if (tmr_done_c && (wcnt_q == WAIT_LAST)) state_d = ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and bookkeeping next values.
    always_comb begin
        gnt_d      = gnt_q;
        ack_d      = 2'b00;
        lcd_en_d   = lcd_en_q;
        lcd_rs_d   = lcd_rs_q;
        lcd_data_d = lcd_data_q;
        own_vld_d  = own_vld_q;
        own_d      = own_q;
        last_d     = last_q;
        srv_d      = srv_q;
        tmr_clr_c  = 1'b0;
`ifdef LCD_ARB_LONG_CMD_EN
        long_d     = long_q;
        wcnt_d     = wcnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|ack_q) begin
                    gnt_d     = 2'b00;
                    own_vld_d = lock_c[srv_q];
                    own_d     = srv_q;
                end else begin
                    if (own_vld_q && !lock_c[own_q]) own_vld_d = 1'b0;
                    if (win_vld_c) begin
                        gnt_d[win_id_c] = 1'b1;
                        lcd_rs_d   = sel_rs_c;
                        lcd_data_d = sel_dat_c;
                        srv_d      = win_id_c;
                        last_d     = win_id_c;
                        tmr_clr_c  = 1'b1;
`ifdef LCD_ARB_LONG_CMD_EN
                        long_d     = is_long_cmd(sel_rs_c, sel_dat_c);
`endif
                    end
                end
            end
            ST_SETUP: if (tmr_done_c) lcd_en_d = 1'b1;
            ST_PULSE: if (tmr_done_c) lcd_en_d = 1'b0;
            ST_HOLD: begin
                if (tmr_done_c) begin
`ifdef LCD_ARB_LONG_CMD_EN
                    if (long_q) wcnt_d = '0;
                    else        ack_d[srv_q] = 1'b1;
`else
                    ack_d[srv_q] = 1'b1;
`endif
                end
            end
            ST_WAIT_LONG: begin
`ifdef LCD_ARB_LONG_CMD_EN
                if (tmr_done_c) begin
                    if (wcnt_q == WAIT_LAST) ack_d[srv_q] = 1'b1;
                    else                     wcnt_d = wcnt_q + WAIT_W'(1);
                end
`endif
            end
            default: ;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Output, lock and fairness registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q      <= 2'b00;
            ack_q      <= 2'b00;
            lcd_en_q   <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= 8'h00;
            busy_q     <= 1'b0;
            own_vld_q  <= 1'b0;
            own_q      <= 1'b0;
            last_q     <= 1'b1;
            srv_q      <= 1'b0;
        end else begin
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            lcd_en_q   <= lcd_en_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_data_q <= lcd_data_d;
            busy_q     <= busy_d;
            own_vld_q  <= own_vld_d;
            own_q      <= own_d;
            last_q     <= last_d;
            srv_q      <= srv_d;
        end
    end

`ifdef LCD_ARB_LONG_CMD_EN
    // Long-command flag and wrap counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            long_q <= 1'b0;
            wcnt_q <= '0;
        end else begin
            long_q <= long_d;
            wcnt_q <= wcnt_d;
        end
    end
`endif

    assign gnt0_o     = gnt_q[0];
    assign gnt1_o     = gnt_q[1];
    assign ack0_o     = ack_q[0];
    assign ack1_o     = ack_q[1];
    assign lcd_rs_o   = lcd_rs_q;
    assign lcd_rw_o   = 1'b0;
    assign lcd_en_o   = lcd_en_q;
    assign lcd_data_o = lcd_data_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: directed scenarios then randomized traffic,
// checked against a transaction-level model of grant order and byte timing.
module tb_lcd_bus_arbiter;

    localparam int CD = 4;
    localparam int CW = 3;

    logic       clk, rst;
    logic       req0, req1, lock0, lock1, rs0, rs1;
    logic [7:0] dat0, dat1;
    logic       gnt0, gnt1, ack0, ack1, lcd_rs, lcd_rw, lcd_en, busy;
    logic [7:0] lcd_data;
    logic [1:0] gnt_v, ack_v;

    assign gnt_v = {gnt1, gnt0};
    assign ack_v = {ack1, ack0};

    lcd_bus_arbiter #(
        .CLK_DIV(CD)
`ifdef LCD_ARB_LONG_CMD_EN
        , .CLEAR_WAIT(CW)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .req0_i(req0), .req1_i(req1), .lock0_i(lock0), .lock1_i(lock1),
        .rs0_i(rs0), .rs1_i(rs1), .dat0_i(dat0), .dat1_i(dat1),
        .gnt0_o(gnt0), .gnt1_o(gnt1), .ack0_o(ack0), .ack1_o(ack1),
        .lcd_rs_o(lcd_rs), .lcd_rw_o(lcd_rw), .lcd_en_o(lcd_en),
        .lcd_data_o(lcd_data), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int nx    = 0;

    // Model state: requester inputs and arbitration memory.
    bit   [1:0] r, l, rsv;
    logic [7:0] dv [2];
    int         own = -1;
    int         last = 1;
    logic       last_rs = 1'b0;
    logic [7:0] last_d = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req0 = r[0]; req1 = r[1]; lock0 = l[0]; lock1 = l[1];
        rs0 = rsv[0]; rs1 = rsv[1]; dat0 = dv[0]; dat1 = dv[1];
    endtask

    // Winner for the next edge from the current inputs and model memory.
    task automatic predict(output int w);
        if (own >= 0 && !l[own]) own = -1;
        if (own >= 0)            w = r[own] ? own : -1;
        else if (r[0] && r[1])   w = 1 - last;
        else if (r[0])           w = 0;
        else if (r[1])           w = 1;
        else                     w = -1;
        if (w >= 0) last = w;
    endtask

    // Called on the negedge right after the grant edge; returns on the
    // negedge after the clk in which ack was high.
    task automatic run_byte(input int who, input bit keep, input bit churn);
        logic       ers;
        logic [7:0] ed;
        bit         lng;
        int         lk;
        ers = rsv[who];
        ed  = dv[who];
`ifdef LCD_ARB_LONG_CMD_EN
        lng = (ers == 1'b0) && (ed == 8'h01 || ed == 8'h02);
`else
        lng = 1'b0;
`endif
        lk = 3 * CD + (lng ? CW * CD : 0);
        if (!keep) begin r[who] = 1'b0; drive(); end
        for (int k = 0; k <= lk + 1; k++) begin
            chk($sformatf("x%0d_gnt_k%0d", nx, k), gnt_v[who], k <= lk);
            chk($sformatf("x%0d_gnt_other_k%0d", nx, k), gnt_v[1-who], 0);
            chk($sformatf("x%0d_ack_k%0d", nx, k), ack_v[who], k == lk);
            chk($sformatf("x%0d_ack_other_k%0d", nx, k), ack_v[1-who], 0);
            chk($sformatf("x%0d_en_k%0d", nx, k), lcd_en, (k >= CD) && (k < 2 * CD));
            chk($sformatf("x%0d_busy_k%0d", nx, k), busy, k < lk);
            chk($sformatf("x%0d_rs_k%0d", nx, k), lcd_rs, ers);
            chk($sformatf("x%0d_data_k%0d", nx, k), lcd_data, ed);
            if (k <= lk) begin
                if (churn) begin
                    dv[who] = 8'($urandom); rsv[who] = 1'($urandom); drive();
                end
                @(negedge clk);
            end
        end
        own = l[who] ? who : -1;
        last_rs = ers;
        last_d  = ed;
        nx++;
    endtask

    // One arbitration opportunity from an idle, unblocked DUT.
    task automatic step_arb(input bit keep, input bit churn, output int w);
        predict(w);
        @(negedge clk);
        chk($sformatf("arb%0d_gnt0", nx), gnt0, w == 0);
        chk($sformatf("arb%0d_gnt1", nx), gnt1, w == 1);
        if (w >= 0) begin
            run_byte(w, keep, churn);
        end else begin
            chk($sformatf("idle%0d_busy", nx), busy, 0);
            chk($sformatf("idle%0d_en", nx), lcd_en, 0);
            chk($sformatf("idle%0d_rs", nx), lcd_rs, last_rs);
            chk($sformatf("idle%0d_data", nx), lcd_data, last_d);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rs"}, lcd_rs, 0);
        chk({tag, "_rw"}, lcd_rw, 0);
        chk({tag, "_en"}, lcd_en, 0);
        chk({tag, "_data"}, lcd_data, 8'h00);
        chk({tag, "_gnt"}, gnt_v, 2'b00);
        chk({tag, "_ack"}, ack_v, 2'b00);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int w;
        r = 0; l = 0; rsv = 0; dv[0] = 8'h00; dv[1] = 8'h00;
        drive();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("post_reset");

        // Single data write with input churn after the grant.
        r[0] = 1; rsv[0] = 1; dv[0] = 8'hA5; drive();
        step_arb(0, 1, w);
        step_arb(0, 0, w);

        // Contention: both requesters held, grants alternate back to back.
        r = 2'b11; rsv = 2'b11; dv[0] = 8'h11; dv[1] = 8'h22; drive();
        repeat (4) step_arb(1, 0, w);
        r = 2'b00; drive();
        step_arb(0, 0, w);

        // Lock: requester 1 keeps the bus for three bytes while 0 waits.
        r = 2'b10; l = 2'b10; dv[1] = 8'h33; drive();
        step_arb(1, 0, w);
        r[0] = 1; dv[0] = 8'h44; drive();
        step_arb(1, 0, w);
        step_arb(1, 0, w);
        r[1] = 0; l[1] = 0; drive();
        step_arb(0, 0, w);

        // Command bytes: clear, home, and a neighbour that is never long.
        foreach (dv[i]) dv[i] = 8'h00;
        rsv = 2'b00;
        r[0] = 1; dv[0] = 8'h01; drive(); step_arb(0, 0, w);
        r[0] = 1; dv[0] = 8'h02; drive(); step_arb(0, 0, w);
        r[0] = 1; dv[0] = 8'h03; drive(); step_arb(0, 0, w);

        // Reset asserted while lcd_en is high.
        r = 2'b10; rsv[1] = 1; dv[1] = 8'h5A; drive();
        predict(w);
        @(negedge clk);
        chk("rst_pre_gnt1", gnt1, w == 1);
        repeat (CD + 1) @(negedge clk);
        chk("rst_pre_en", lcd_en, 1);
        #2 rst = 1'b0;
        #1 chk_reset_vals("rst_async");
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold_ack", ack_v, 2'b00);
        end
        own = -1; last = 1; last_rs = 1'b0; last_d = 8'h00;
        r = 2'b11; rsv = 2'b11; dv[0] = 8'h66; dv[1] = 8'h77; drive();
        rst = 1'b1;
        step_arb(0, 0, w);
        step_arb(0, 0, w);
        step_arb(0, 0, w);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            for (int j = 0; j < 2; j++) begin
                r[j]   = 1'($urandom_range(0, 1));
                l[j]   = ($urandom_range(0, 2) == 0);
                rsv[j] = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 4))
                    0:       dv[j] = 8'h01;
                    1:       dv[j] = 8'h02;
                    2:       dv[j] = 8'h03;
                    default: dv[j] = 8'($urandom);
                endcase
            end
            drive();
            step_arb(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
